// File: rtl/mux_scan_controller.sv
// Sequences the select lines of a 16:1 mux across the enabled channels.
// Each channel settles for DWELL cycles and is then sampled for one cycle.
// Every output is a register loaded from the next-state logic.
module mux_scan_controller #(
   parameter int unsigned DWELL = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        cont,
   input  logic [15:0] mask,
   input  logic        mux_y,
   output logic [3:0]  select,
   output logic        sample,
   output logic        busy,
   output logic        done,
   output logic [15:0] result
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   // A continuous restart counts the DONE cycle as the first settle cycle,
   // so the pass period stays N*(DWELL+1).
   localparam logic [3:0] DWELL_LD = 4'(DWELL);
   localparam logic [3:0] DWELL_RS = 4'(DWELL - 1);

   state_t      state, state_nxt;
   logic [15:0] mask_lat, mask_lat_nxt;
   logic [15:0] result_nxt;
   logic [3:0]  select_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        sample_nxt, busy_nxt, done_nxt;
   logic [4:0]  first_new, first_lat, next_lat;

   // Lowest enabled channel at or above 'from'; returns {found, index}.
   function automatic logic [4:0] next_enabled(input logic [15:0] m, input logic [4:0] from);
      logic [4:0] r;
      r = '0;
      for (int i = 15; i >= 0; i--) begin
         if (m[i] && (5'(i) >= from)) r = {1'b1, 4'(i)};
      end
      return r;
   endfunction

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         select   <= '0;
         sample   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         mask_lat <= '0;
         cnt      <= '0;
      end else begin
         state    <= state_nxt;
         select   <= select_nxt;
         sample   <= sample_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         result   <= result_nxt;
         mask_lat <= mask_lat_nxt;
         cnt      <= cnt_nxt;
      end
   end

   // Next-state and next-output logic; abort overrides every active state.
   always_comb begin
      first_new    = next_enabled(mask, 5'd0);
      first_lat    = next_enabled(mask_lat, 5'd0);
      next_lat     = next_enabled(mask_lat, {1'b0, select} + 5'd1);
      state_nxt    = state;
      select_nxt   = select;
      sample_nxt   = 1'b0;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      result_nxt   = result;
      mask_lat_nxt = mask_lat;
      cnt_nxt      = cnt;

      case (state)
         IDLE: begin
            if (start && !abort) begin
               mask_lat_nxt = mask;
               result_nxt   = '0;
               if (first_new[4]) begin
                  select_nxt = first_new[3:0];
                  cnt_nxt    = DWELL_LD;
                  busy_nxt   = 1'b1;
                  state_nxt  = SETTLE;
               end else begin
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         SETTLE: begin
            if (cnt <= 4'd1) begin
               cnt_nxt    = '0;
               sample_nxt = 1'b1;
               state_nxt  = SAMPLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         SAMPLE: begin
            result_nxt[select] = mux_y;
            if (next_lat[4]) begin
               select_nxt = next_lat[3:0];
               cnt_nxt    = DWELL_LD;
               state_nxt  = SETTLE;
            end else begin
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = DONE;
               // Pre-position the mux so the DONE cycle already settles the next pass.
               if (cont && first_lat[4]) select_nxt = first_lat[3:0];
            end
         end
         DONE: begin
            if (cont) begin
               result_nxt = '0;
               if (first_lat[4]) begin
                  select_nxt = first_lat[3:0];
                  busy_nxt   = 1'b1;
                  if (DWELL_RS == 4'd0) begin
                     cnt_nxt    = '0;
                     sample_nxt = 1'b1;
                     state_nxt  = SAMPLE;
                  end else begin
                     cnt_nxt   = DWELL_RS;
                     state_nxt = SETTLE;
                  end
               end else begin
                  done_nxt  = 1'b1;
                  state_nxt = DONE;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (abort && (state != IDLE)) begin
         state_nxt  = IDLE;
         select_nxt = select;
         sample_nxt = 1'b0;
         busy_nxt   = 1'b0;
         done_nxt   = 1'b0;
         result_nxt = result;
         cnt_nxt    = '0;
      end
   end

endmodule

// File: doc/mux_scan_controller.md
MUX_SCAN_CONTROLLER -- requirements
Module: mux_scan_controller

Interface
REQ-001 Parameter DWELL, default 2, number of settle cycles each select value is held before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  single-cycle request to begin a scan pass; sampled in IDLE only.
REQ-005 abort  input  1  synchronous cancel of an active scan.
REQ-006 cont  input  1  continuous mode; sampled at end of each pass.
REQ-007 mask  input  16  channel enable bits, bit k enables mux input k; latched on accepted start.
REQ-008 mux_y  input  1  output of the 16:1 mux being sequenced.
REQ-009 select  output  4  drives the 16:1 mux select lines.
REQ-010 sample  output  1  one-cycle strobe marking the cycle in which mux_y is captured.
REQ-011 busy  output  1  high while a pass is in progress.
REQ-012 done  output  1  one-cycle pulse at pass completion.
REQ-013 result  output  16  captured mux_y per channel; bit k holds the sample of channel k.

Function
REQ-014 FSM states: IDLE, SETTLE, SAMPLE, DONE; all outputs registered.
REQ-015 IDLE, start=1, mask!=0: latch mask, clear result to 0, select = lowest enabled index, load dwell counter with DWELL, busy=1, go SETTLE.
REQ-016 IDLE, start=1, mask==0: result cleared, go DONE; busy stays 0, done pulses on the next edge.
REQ-017 SETTLE: decrement dwell counter each cycle; after DWELL cycles go SAMPLE; select held constant.
REQ-018 SAMPLE (one cycle, sample=1): on the closing edge, result[select] <= mux_y.
REQ-019 SAMPLE, further enabled channel above select: select = next higher enabled index (gaps skipped in zero cycles), reload counter, go SETTLE.
REQ-020 SAMPLE, last enabled channel: go DONE with done=1 and busy=0 on the same edge; no wrap past index 15 within a pass.
REQ-021 Timing: with N enabled channels, done is high during the cycle after edge start_edge + N*(DWELL+1); sample strobes occur every DWELL+1 cycles.
REQ-022 DONE, cont=1: restart using the latched mask (result cleared, busy=1) on the next edge; cont=0: return to IDLE.
REQ-023 start while busy or in DONE is ignored; mask changes after latch have no effect until the next accepted start.
REQ-024 abort=1 in SETTLE, SAMPLE or DONE: next edge goes to IDLE with busy=0, done=0, sample=0; result keeps partial contents; abort beats sample and start in the same cycle.
REQ-025 select holds its last value in IDLE; result holds until the next accepted start.

Reset
REQ-026 rst_n=0 immediately forces IDLE, select=0, sample=0, busy=0, done=0, result=16'h0000, latched mask=0, dwell counter=0, regardless of clock or mid-pass state.
REQ-027 After rst_n deasserts, the first start is accepted on the next rising edge.

Verification (DWELL=2, mux data pattern 16'b1010_1010_1010_1010 so mux_y = select[0])
REQ-028 mask=16'hFFFF, start pulse -> select steps 0..15, 16 sample strobes 3 cycles apart, done at start edge+48, result=16'hAAAA.
REQ-029 mask=16'h8001 -> select 0 then 15, done at start edge+6, result=16'h8000.
REQ-030 mask=16'h0000, start -> busy never high, done one cycle after start, result=16'h0000.
REQ-031 mask=16'hFFFF, abort during channel 5 settle -> busy low next edge, no done, result=16'h000A.
REQ-032 cont=1, mask=16'h0003 -> done every 6 cycles, result=16'h0002 after each pass; cont=0 -> IDLE after current pass.
REQ-033 rst_n low mid-pass (select=7) -> all outputs zero asynchronously; a new start then completes a normal pass.
